bnn_maxpool_stream: RTL
=======================

Name: bnn_maxpool_stream

Overview:
- Streaming binary max-pool stage for the BNN datapath. Sits between a binary conv layer's output and the next layer's input buffer.
- Accepts one pixel per beat, all channels in parallel, in raster order. Holds the last (POOL_DIM-1) rows plus POOL_DIM pixels in a shift-register line buffer.
- Emits one pooled pixel for each stride-aligned POOL_DIM x POOL_DIM window, using a valid/ready handshake on both sides.
- Generalises the earlier fixed OR-window buffer with stride, a frame position tracker, backpressure, a frame-last flag and a selectable reduction mode.

Parameters:
- IMG_DIM, 28: input image width and height in pixels (square image).
- POOL_DIM, 2: pooling window side length, >= 2 and <= IMG_DIM.
- STRIDE, 2: window step in both directions, >= 1.
- CHANNELS, 1: number of binary channels per pixel.
- Derived: OUT_DIM = (IMG_DIM - POOL_DIM) / STRIDE + 1 (integer division).
- Derived: BUF_LEN = IMG_DIM * (POOL_DIM - 1) + POOL_DIM.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous active-low reset.
- i_valid, input, 1: upstream pixel valid.
- o_ready, output, 1: block can accept a pixel.
- i_data, input, CHANNELS: binary pixel, one bit per channel.
- o_valid, output, 1: pooled pixel valid.
- i_ready, input, 1: downstream can accept.
- o_data, output, CHANNELS: pooled pixel.
- o_last, output, 1: qualifies the final pooled pixel of a frame.

Behaviour:
- Reset: o_valid=0, o_data=0, o_last=0. Column and row counters = 0. Stride phase counters = 0. Line buffer contents are don't-care and are never read before they are refilled.
- o_ready = !o_valid || i_ready, combinational. This gives a single-entry output stage with full throughput when downstream is always ready.
- Accept: a beat is accepted when i_valid && o_ready. On accept, i_data shifts into buffer position 0 and every entry moves up by one. Nothing shifts without an accept.
- Position tracking:
  - col counts 0..IMG_DIM-1 and wraps to 0 with row incrementing.
  - row wraps to 0 after the last pixel (col = IMG_DIM-1, row = IMG_DIM-1). The next frame then starts with no idle cycle.
- Stride phase counters: separate row and column counters, reset to 0 at col/row = POOL_DIM-1 and cycling modulo STRIDE. No divider or modulo operator in RTL.
- Window-complete condition, evaluated on the accepted pixel: row >= POOL_DIM-1, col >= POOL_DIM-1, both phase counters = 0.
- Ignored pixels: rows and columns beyond the last full window are consumed but produce no output.
- Window taps, evaluated on buffer contents including the pixel just accepted: for r,c in 0..POOL_DIM-1, tap(r,c) = buf[r*IMG_DIM + c]. Index 0 is the newest pixel.
- Reduction (default): o_data[ch] = OR of all POOL_DIM^2 taps of channel ch.
- Output register:
  - Loaded on the accept edge when the window is complete. o_valid is set one cycle after the completing accept (latency 1).
  - o_last = 1 when the completing pixel is the last complete window of the frame, i.e. output index (OUT_DIM-1, OUT_DIM-1).
- Output handshake: o_valid is cleared on o_valid && i_ready unless a new window completes on the same edge. In that case the register reloads and o_valid stays 1 (back-to-back transfer).
- Stability: o_data and o_last hold stable while o_valid && !i_ready.
- Backpressure: while stalled, o_ready = 0, so upstream holds and the counters freeze.
- Reset mid-frame: outputs, counters and phases return to their reset values immediately. The next accepted pixel is treated as (row 0, col 0).
- Width rules: counters are $clog2(IMG_DIM) bits; phase counters are $clog2(STRIDE) bits, minimum 1.

Optional Feature:
- Macro: POOL_MAJORITY_EN.
- Defined: the reduction becomes a per-channel majority vote. o_data[ch] = 1 iff popcount(taps of ch) >= (POOL_DIM^2 + 1) / 2 (integer division). The popcount adder is $clog2(POOL_DIM^2 + 1) bits wide. Timing and handshake are unchanged.
- Undefined: OR reduction only, and no popcount logic is synthesised.

Test Plan:
- IMG_DIM=4, POOL_DIM=2, STRIDE=2, CHANNELS=2, always ready; single pixel at (row 1, col 2) = 2'b01, all others 0 -> 4 outputs in order 00, 01, 00, 00. Only the 4th has o_last=1. Each output appears 1 cycle after the pixel at (1,1), (1,3), (3,1), (3,3).
- Same config, i_ready low for 5 cycles while o_valid=1 -> o_ready=0, o_data held, counters frozen. Releasing i_ready produces no lost or duplicated pixels: exactly 4 outputs per frame.
- IMG_DIM=5, POOL_DIM=2, STRIDE=2 -> OUT_DIM=2. Row 4 and column 4 are all ones, all other pixels zero -> all 4 outputs are 0, and only 4 outputs are produced.
- IMG_DIM=4, POOL_DIM=3, STRIDE=1, CHANNELS=1, all-ones frame -> 4 outputs of 1, after pixels (2,2), (2,3), (3,2), (3,3).
- Two frames back-to-back with continuous i_valid; assert rst_n=0 at pixel 6 of frame 2 -> after reset, o_valid=0 and o_last=0. The next full frame gives the correct 4 outputs.
- With POOL_MAJORITY_EN, IMG_DIM=4, POOL_DIM=2, STRIDE=2: window with 2 ones -> 1; window with 1 one -> 0. Without the macro, both windows give 1.

Source files
------------

// File: rtl/bnn_maxpool_stream.sv
// Streaming binary max-pool over stride-aligned POOL_DIM x POOL_DIM windows; define POOL_MAJORITY_EN for majority-vote reduction.
// Latency 1 cycle from completing pixel to o_valid; single-entry output stage, o_ready drops while a result is held.
module bnn_maxpool_stream #(
    parameter int IMG_DIM  = 28,
    parameter int POOL_DIM = 2,
    parameter int STRIDE   = 2,
    parameter int CHANNELS = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [CHANNELS-1:0] i_data,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [CHANNELS-1:0] o_data,
    output logic                o_last
);

    localparam int OUT_DIM  = (IMG_DIM - POOL_DIM) / STRIDE + 1;
    localparam int BUF_LEN  = IMG_DIM * (POOL_DIM - 1) + POOL_DIM;
    localparam int CW       = $clog2(IMG_DIM);
    localparam int PW       = (STRIDE > 1) ? $clog2(STRIDE) : 1;
    localparam int LAST_POS = POOL_DIM - 1 + (OUT_DIM - 1) * STRIDE;

    localparam logic [CW-1:0] C_MAX  = CW'(IMG_DIM - 1);
    localparam logic [CW-1:0] C_WIN0 = CW'(POOL_DIM - 1);
    localparam logic [CW-1:0] C_LAST = CW'(LAST_POS);
    localparam logic [PW-1:0] P_MAX  = PW'(STRIDE - 1);

    // Entry k holds the pixel accepted k+1 beats ago; the live input acts as entry 0.
    logic [CHANNELS-1:0] r_buf [0:BUF_LEN-2];

    logic [CW-1:0]       r_col, r_row, w_col_nxt, w_row_nxt;
    logic [PW-1:0]       r_cph, r_rph, w_cph_nxt, w_rph_nxt;
    logic                r_valid, r_last;
    logic [CHANNELS-1:0] r_data;
    logic                w_acc, w_hit, w_last_win;
    logic [CHANNELS-1:0] w_red;

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_last  = r_last;
    assign o_ready = !r_valid || i_ready;
    assign w_acc   = i_valid && o_ready;

    assign w_hit      = (r_row >= C_WIN0) && (r_col >= C_WIN0) && (r_cph == '0) && (r_rph == '0);
    assign w_last_win = w_hit && (r_row == C_LAST) && (r_col == C_LAST);

    // Phases are pinned to 0 at the first full-window row/column, then step modulo STRIDE.
    always_comb begin
        w_col_nxt = r_col + 1'b1;
        w_row_nxt = r_row;
        w_cph_nxt = r_cph;
        w_rph_nxt = r_rph;
        if (r_col == C_MAX) begin
            w_col_nxt = '0;
            w_row_nxt = (r_row == C_MAX) ? '0 : r_row + 1'b1;
            w_rph_nxt = ((w_row_nxt == C_WIN0) || (r_rph == P_MAX)) ? '0 : r_rph + 1'b1;
        end
        w_cph_nxt = ((w_col_nxt == C_WIN0) || (r_cph == P_MAX)) ? '0 : r_cph + 1'b1;
    end

`ifdef POOL_MAJORITY_EN
    localparam int PCW = $clog2(POOL_DIM * POOL_DIM + 1);
    localparam logic [PCW-1:0] MAJ_TH = PCW'((POOL_DIM * POOL_DIM + 1) / 2);
    logic [PCW-1:0] w_cnt [CHANNELS];

    always_comb begin
        for (int ch = 0; ch < CHANNELS; ch++) begin
            w_cnt[ch] = PCW'(i_data[ch]);
            for (int c = 1; c < POOL_DIM; c++)
                w_cnt[ch] = w_cnt[ch] + PCW'(r_buf[c-1][ch]);
            for (int r = 1; r < POOL_DIM; r++)
                for (int c = 0; c < POOL_DIM; c++)
                    w_cnt[ch] = w_cnt[ch] + PCW'(r_buf[r*IMG_DIM+c-1][ch]);
            w_red[ch] = (w_cnt[ch] >= MAJ_TH);
        end
    end
`else
    always_comb begin
        w_red = i_data;
        for (int c = 1; c < POOL_DIM; c++)
            w_red = w_red | r_buf[c-1];
        for (int r = 1; r < POOL_DIM; r++)
            for (int c = 0; c < POOL_DIM; c++)
                w_red = w_red | r_buf[r*IMG_DIM+c-1];
    end
`endif

    // Line buffer needs no reset: every tap is rewritten before a window can complete.
    always_ff @(posedge clk) begin
        if (w_acc) begin
            r_buf[0] <= i_data;
            for (int k = 1; k < BUF_LEN - 1; k++)
                r_buf[k] <= r_buf[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col   <= '0;
            r_row   <= '0;
            r_cph   <= '0;
            r_rph   <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_last  <= 1'b0;
        end else begin
            if (w_acc) begin
                r_col <= w_col_nxt;
                r_row <= w_row_nxt;
                r_cph <= w_cph_nxt;
                r_rph <= w_rph_nxt;
            end
            if (w_acc && w_hit) begin
                r_valid <= 1'b1;
                r_data  <= w_red;
                r_last  <= w_last_win;
            end else if (r_valid && i_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

endmodule
